// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared registered ALU pipeline.
// Grants one op per cycle, tags it with its requester ID and routes results back.
module alu_req_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [2:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [2:0]   req1_op,
    output logic         issue_valid,
    output logic [N-1:0] issue_a,
    output logic [N-1:0] issue_b,
    output logic [2:0]   issue_op,
    output logic         issue_sum,
    output logic         issue_rest,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic         rsp0_valid,
    output logic         rsp1_valid,
    output logic [N-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    input  logic         flush_req,
    output logic         flush_done,
    output logic         busy
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]     state;
    logic           last_id;
    logic           grant_vld_p0;
    logic           grant_id_p0;
    logic [N-1:0]   grant_a_p0;
    logic [N-1:0]   grant_b_p0;
    logic [2:0]     grant_op_p0;
    logic [LAT-1:0] tag_vld_p;
    logic [LAT-1:0] tag_id_p;
    logic           tail_vld;
    logic           tail_id;

    function automatic logic [1:0] decode_op(input logic [2:0] op);
        return {op == 3'b000, op == 3'b001};
    endfunction

    // Stage p0: grant selection and operand mux (combinational)
    always_comb begin
        grant_vld_p0 = 1'b0;
        grant_id_p0  = 1'b0;
        if (state == ST_RUN && !flush_req) begin
            if (req0_valid && req1_valid) begin
                grant_vld_p0 = 1'b1;
                grant_id_p0  = ~last_id;
            end else if (req0_valid) begin
                grant_vld_p0 = 1'b1;
            end else if (req1_valid) begin
                grant_vld_p0 = 1'b1;
                grant_id_p0  = 1'b1;
            end
        end
    end

    assign grant_a_p0  = grant_id_p0 ? req1_a  : req0_a;
    assign grant_b_p0  = grant_id_p0 ? req1_b  : req0_b;
    assign grant_op_p0 = grant_id_p0 ? req1_op : req0_op;
    assign req0_ready  = grant_vld_p0 & ~grant_id_p0;
    assign req1_ready  = grant_vld_p0 &  grant_id_p0;

    // Stage p1: issue register feeding the ALU
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issue_valid <= 1'b0;
            issue_a     <= '0;
            issue_b     <= '0;
            issue_op    <= '0;
            issue_sum   <= 1'b0;
            issue_rest  <= 1'b0;
        end else begin
            issue_valid <= grant_vld_p0;
            if (grant_vld_p0) begin
                issue_a                 <= grant_a_p0;
                issue_b                 <= grant_b_p0;
                issue_op                <= grant_op_p0;
                {issue_sum, issue_rest} <= decode_op(grant_op_p0);
            end
        end
    end

    // Reset leaves last_id at 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_id <= 1'b1;
        end else if (grant_vld_p0) begin
            last_id <= grant_id_p0;
        end
    end

    // Tag pipe loads alongside the issue register so the tail lines up with alu_result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld_p <= '0;
            tag_id_p  <= '0;
        end else begin
            tag_vld_p[0] <= grant_vld_p0;
            tag_id_p[0]  <= grant_id_p0;
            for (int i = 1; i < LAT; i++) begin
                tag_vld_p[i] <= tag_vld_p[i-1];
                tag_id_p[i]  <= tag_id_p[i-1];
            end
        end
    end

    assign tail_vld = tag_vld_p[LAT-1];
    assign tail_id  = tag_id_p[LAT-1];
    assign busy     = issue_valid | (|tag_vld_p);

    // Response stage: capture ALU output and steer the pulse by tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            rsp0_valid <= tail_vld & ~tail_id;
            rsp1_valid <= tail_vld &  tail_id;
            if (tail_vld) begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_RUN:   if (flush_req) state <= ST_DRAIN;
                ST_DRAIN: if (!busy) begin
                    state      <= ST_DONE;
                    flush_done <= 1'b1;
                end
                ST_DONE:  state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: directed vector table, randomized traffic against
// a queue-based reference model, and reset/flush corner sequences.
module tb_alu_req_arbiter;

    localparam int N   = 4;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid, flush_req;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         req0_ready, req1_ready;
    logic         issue_valid, issue_sum, issue_rest;
    logic [N-1:0] issue_a, issue_b;
    logic [2:0]   issue_op;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic         rsp0_valid, rsp1_valid, flush_done, busy;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;

    alu_req_arbiter #(.N(N), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .issue_valid(issue_valid), .issue_a(issue_a), .issue_b(issue_b),
        .issue_op(issue_op), .issue_sum(issue_sum), .issue_rest(issue_rest),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .flush_req(flush_req), .flush_done(flush_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU behaviour: {flags{N,Z,C,V}, result}
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] op);
        logic [4:0] w;
        if (op == 3'b000)      w = {1'b0, a} + {1'b0, b};
        else if (op == 3'b001) w = {1'b0, a} - {1'b0, b};
        else                   w = {1'b0, a ^ b};
        return {1'b0, w[3:0] == 4'h0, w[4], 1'b0, w[3:0]};
    endfunction

    // Registered ALU stage: result appears one cycle after the issue register
    logic [7:0] stub_q = '0;
    always @(posedge clk) stub_q <= alu_f(issue_a, issue_b, issue_op);
    assign alu_result = stub_q[3:0];
    assign alu_flags  = stub_q[7:4];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at step %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         id;
        logic [3:0] a, b;
        logic [2:0] op;
        int         rem;
    } op_t;

    op_t        q[$];
    int         m_mode;   // 0 running, 1 draining, 2 flush complete
    int         m_last;
    logic       e_iv, e_isum, e_irest, e_rsp0, e_rsp1, e_fd;
    logic [3:0] e_ia, e_ib, e_res, e_flags;
    logic [2:0] e_iop;

    task automatic model_reset();
        q.delete();
        m_mode = 0; m_last = 1;
        e_iv = 0; e_isum = 0; e_irest = 0; e_rsp0 = 0; e_rsp1 = 0; e_fd = 0;
        e_ia = 0; e_ib = 0; e_res = 0; e_flags = 0; e_iop = 0;
    endtask

    task automatic model_grant(output int en, output int id);
        en = 0; id = 0;
        if (m_mode == 0 && !flush_req) begin
            if (req0_valid && req1_valid) begin en = 1; id = 1 - m_last; end
            else if (req0_valid) en = 1;
            else if (req1_valid) begin en = 1; id = 1; end
        end
    endtask

    task automatic model_edge();
        int en, id;
        bit was_busy;
        op_t o;
        logic [7:0] r;
        model_grant(en, id);
        was_busy = (q.size() != 0);
        e_rsp0 = 0; e_rsp1 = 0;
        foreach (q[i]) q[i].rem--;
        if (q.size() != 0 && q[0].rem == 0) begin
            o = q.pop_front();
            r = alu_f(o.a, o.b, o.op);
            e_res = r[3:0]; e_flags = r[7:4];
            if (o.id == 0) e_rsp0 = 1; else e_rsp1 = 1;
        end
        e_iv = (en != 0);
        if (en != 0) begin
            o.id  = id;
            o.a   = (id == 0) ? req0_a  : req1_a;
            o.b   = (id == 0) ? req0_b  : req1_b;
            o.op  = (id == 0) ? req0_op : req1_op;
            o.rem = LAT;
            e_ia = o.a; e_ib = o.b; e_iop = o.op;
            e_isum = (o.op == 3'b000); e_irest = (o.op == 3'b001);
            q.push_back(o);
            m_last = id;
        end
        e_fd = 0;
        case (m_mode)
            0: if (flush_req) m_mode = 1;
            1: if (!was_busy) begin m_mode = 2; e_fd = 1; end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_all();
        int en, id;
        model_grant(en, id);
        chk("req0_ready", int'(req0_ready), int'(en != 0 && id == 0));
        chk("req1_ready", int'(req1_ready), int'(en != 0 && id == 1));
        chk("issue_valid", int'(issue_valid), int'(e_iv));
        chk("issue_a", int'(issue_a), int'(e_ia));
        chk("issue_b", int'(issue_b), int'(e_ib));
        chk("issue_op", int'(issue_op), int'(e_iop));
        chk("issue_sum", int'(issue_sum), int'(e_isum));
        chk("issue_rest", int'(issue_rest), int'(e_irest));
        chk("rsp0_valid", int'(rsp0_valid), int'(e_rsp0));
        chk("rsp1_valid", int'(rsp1_valid), int'(e_rsp1));
        chk("rsp_result", int'(rsp_result), int'(e_res));
        chk("rsp_flags", int'(rsp_flags), int'(e_flags));
        chk("flush_done", int'(flush_done), int'(e_fd));
        chk("busy", int'(busy), int'(q.size() != 0));
    endtask

    // Called at posedge+2 with inputs applied: sample at posedge+4, then advance.
    task automatic settle_and_check();
        #2;
        check_all();
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic check_reset_zero(input string tag);
        chk({tag, "_issue_valid"}, int'(issue_valid), 0);
        chk({tag, "_issue_a"}, int'(issue_a), 0);
        chk({tag, "_issue_op"}, int'(issue_op), 0);
        chk({tag, "_issue_sum"}, int'(issue_sum), 0);
        chk({tag, "_rsp0"}, int'(rsp0_valid), 0);
        chk({tag, "_rsp1"}, int'(rsp1_valid), 0);
        chk({tag, "_rsp_result"}, int'(rsp_result), 0);
        chk({tag, "_flush_done"}, int'(flush_done), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic v0, v1, fl;
        int   ds;
        logic rdy0, rdy1, iv, sum, rest, rsp0, rsp1, fd, bsy;
        logic [3:0] res;
    } vec_t;

    function automatic vec_t mk(input int v0, input int v1, input int fl, input int ds,
                                input int rdy0, input int rdy1, input int iv,
                                input int sum, input int rest, input int rsp0,
                                input int rsp1, input int fd, input int bsy, input int res);
        vec_t r;
        r.v0 = v0[0]; r.v1 = v1[0]; r.fl = fl[0]; r.ds = ds;
        r.rdy0 = rdy0[0]; r.rdy1 = rdy1[0]; r.iv = iv[0]; r.sum = sum[0];
        r.rest = rest[0]; r.rsp0 = rsp0[0]; r.rsp1 = rsp1[0]; r.fd = fd[0];
        r.bsy = bsy[0]; r.res = res[3:0];
        return r;
    endfunction

    // Operand sets: {a0, b0, op0, a1, b1, op1}
    logic [21:0] dset [0:3];
    vec_t        vt [0:28];

    initial begin
        dset[0] = {4'h3, 4'h5, 3'b000, 4'h7, 4'h2, 3'b001};
        dset[1] = {4'h1, 4'h1, 3'b000, 4'h9, 4'h4, 3'b101};
        dset[2] = {4'h0, 4'h0, 3'b000, 4'hf, 4'h1, 3'b001};
        dset[3] = {4'h2, 4'h3, 3'b000, 4'h6, 4'h1, 3'b110};
        //          v0 v1 fl ds  r0 r1 iv su re s0 s1 fd bz res
        vt[0]  = mk(1, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0, 'h0);
        vt[1]  = mk(0, 1, 0, 0,  0, 1, 1, 1, 0, 0, 0, 0, 1, 'h0);
        vt[2]  = mk(1, 1, 0, 1,  1, 0, 1, 0, 1, 0, 0, 0, 1, 'h0);
        vt[3]  = mk(1, 1, 0, 1,  0, 1, 1, 1, 0, 1, 0, 0, 1, 'h8);
        vt[4]  = mk(1, 1, 0, 1,  1, 0, 1, 0, 0, 0, 1, 0, 1, 'h5);
        vt[5]  = mk(1, 1, 0, 1,  0, 1, 1, 1, 0, 1, 0, 0, 1, 'h2);
        vt[6]  = mk(1, 1, 0, 1,  1, 0, 1, 0, 0, 0, 1, 0, 1, 'hd);
        vt[7]  = mk(1, 1, 0, 1,  0, 1, 1, 1, 0, 1, 0, 0, 1, 'h2);
        vt[8]  = mk(0, 0, 0, 1,  0, 0, 1, 0, 0, 0, 1, 0, 1, 'hd);
        vt[9]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 0, 0, 1, 'h2);
        vt[10] = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'hd);
        vt[11] = mk(0, 1, 0, 2,  0, 1, 0, 0, 0, 0, 0, 0, 0, 'h0);
        vt[12] = mk(0, 1, 0, 2,  0, 1, 1, 0, 1, 0, 0, 0, 1, 'h0);
        vt[13] = mk(0, 1, 0, 2,  0, 1, 1, 0, 1, 0, 0, 0, 1, 'h0);
        vt[14] = mk(0, 1, 0, 2,  0, 1, 1, 0, 1, 0, 1, 0, 1, 'he);
        vt[15] = mk(0, 1, 0, 2,  0, 1, 1, 0, 1, 0, 1, 0, 1, 'he);
        vt[16] = mk(0, 0, 0, 2,  0, 0, 1, 0, 1, 0, 1, 0, 1, 'he);
        vt[17] = mk(0, 0, 0, 2,  0, 0, 0, 0, 1, 0, 1, 0, 1, 'he);
        vt[18] = mk(0, 0, 0, 2,  0, 0, 0, 0, 1, 0, 1, 0, 0, 'he);
        vt[19] = mk(1, 1, 0, 3,  1, 0, 0, 0, 1, 0, 0, 0, 0, 'h0);
        vt[20] = mk(1, 1, 0, 3,  0, 1, 1, 1, 0, 0, 0, 0, 1, 'h0);
        vt[21] = mk(1, 1, 1, 3,  0, 0, 1, 0, 0, 0, 0, 0, 1, 'h0);
        vt[22] = mk(1, 1, 0, 3,  0, 0, 0, 0, 0, 1, 0, 0, 1, 'h5);
        vt[23] = mk(1, 1, 0, 3,  0, 0, 0, 0, 0, 0, 1, 0, 0, 'h7);
        vt[24] = mk(1, 1, 0, 3,  0, 0, 0, 0, 0, 0, 0, 1, 0, 'h0);
        vt[25] = mk(1, 1, 0, 3,  1, 0, 0, 0, 0, 0, 0, 0, 0, 'h0);
        vt[26] = mk(0, 0, 0, 3,  0, 0, 1, 1, 0, 0, 0, 0, 1, 'h0);
        vt[27] = mk(0, 0, 0, 3,  0, 0, 0, 1, 0, 0, 0, 0, 1, 'h0);
        vt[28] = mk(0, 0, 0, 3,  0, 0, 0, 1, 0, 1, 0, 0, 0, 'h5);
    end

    int fl_cnt;

    initial begin
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; flush_req = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_zero("reset");
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 29; i++) begin
            req0_valid = vt[i].v0;
            req1_valid = vt[i].v1;
            flush_req  = vt[i].fl;
            {req0_a, req0_b, req0_op, req1_a, req1_b, req1_op} = dset[vt[i].ds];
            settle_and_check();
            chk($sformatf("t%0d_rdy0", i), int'(req0_ready), int'(vt[i].rdy0));
            chk($sformatf("t%0d_rdy1", i), int'(req1_ready), int'(vt[i].rdy1));
            chk($sformatf("t%0d_iv", i), int'(issue_valid), int'(vt[i].iv));
            chk($sformatf("t%0d_sum", i), int'(issue_sum), int'(vt[i].sum));
            chk($sformatf("t%0d_rest", i), int'(issue_rest), int'(vt[i].rest));
            chk($sformatf("t%0d_rsp0", i), int'(rsp0_valid), int'(vt[i].rsp0));
            chk($sformatf("t%0d_rsp1", i), int'(rsp1_valid), int'(vt[i].rsp1));
            chk($sformatf("t%0d_fdone", i), int'(flush_done), int'(vt[i].fd));
            chk($sformatf("t%0d_busy", i), int'(busy), int'(vt[i].bsy));
            if (vt[i].rsp0 || vt[i].rsp1)
                chk($sformatf("t%0d_res", i), int'(rsp_result), int'(vt[i].res));
            advance();
        end

        // Randomized traffic with occasional held flush requests
        fl_cnt = 0;
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
            req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
            if (fl_cnt > 0) begin
                flush_req = 1; fl_cnt--;
            end else if ($urandom_range(0, 29) == 0) begin
                flush_req = 1; fl_cnt = $urandom_range(0, 3);
            end else begin
                flush_req = 0;
            end
            settle_and_check();
            advance();
        end

        // Idle out, then reset with two ops in flight
        req0_valid = 0; req1_valid = 0; flush_req = 0;
        repeat (6) begin settle_and_check(); advance(); end
        req0_valid = 1; req1_valid = 1;
        req0_a = 4'h3; req0_b = 4'h4; req0_op = 3'b000;
        req1_a = 4'h9; req1_b = 4'h1; req1_op = 3'b001;
        repeat (2) begin settle_and_check(); advance(); end
        req0_valid = 0; req1_valid = 0;
        reset = 1'b1;
        #1;
        check_reset_zero("midrst");
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (4) begin settle_and_check(); advance(); end
        req0_valid = 1; req1_valid = 1;
        settle_and_check();
        chk("post_reset_tie_rdy0", int'(req0_ready), 1);
        chk("post_reset_tie_rdy1", int'(req1_ready), 0);
        advance();
        req0_valid = 0; req1_valid = 0;
        repeat (5) begin settle_and_check(); advance(); end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
